// File: rtl/axis_mux_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_mux_scheduler                                                       |
// | Burst-limited, work-conserving select scheduler for a 2:1 AXIS mux.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_mux_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s0_tvalid,
  input  logic             s0_tready,
  input  logic             s1_tvalid,
  input  logic             s1_tready,
  input  logic             enable,
  input  logic             force_sel,
  input  logic [CNT_W-1:0] burst_len,
  output logic             select_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [31:0]      switch_count,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GRANT  = 2'd2,
    ST_FORCED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   C_EXT_ONE = (CNT_W+1)'(1);
  localparam logic [31:0]      C_SW_ONE  = 32'd1;

  state_t           r_state, w_state_nxt;
  logic             r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_beat, w_beat_nxt;
  logic [31:0]      r_sw, w_sw_nxt;

  logic             w_cur_v, w_cur_r, w_oth_v, w_hs;
  logic             w_switch, w_burst_end;
  logic [CNT_W-1:0] w_beat_inc;
  logic [CNT_W:0]   w_beat_p1;

  // Only the source currently selected can contribute beats; the other side
  // may still handshake during the mux's own select lag.
  assign w_cur_v = r_sel ? s1_tvalid : s0_tvalid;
  assign w_cur_r = r_sel ? s1_tready : s0_tready;
  assign w_oth_v = r_sel ? s0_tvalid : s1_tvalid;
  assign w_hs    = w_cur_v & w_cur_r;

  // Saturating increment so an unlimited burst never wraps.
  assign w_beat_inc  = (w_hs && (r_beat != C_CNT_MAX)) ? (r_beat + C_CNT_ONE) : r_beat;
  assign w_beat_p1   = {1'b0, r_beat} + C_EXT_ONE;
  assign w_burst_end = (burst_len != '0) && w_hs && (w_beat_p1 >= {1'b0, burst_len});

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_beat_nxt  = r_beat;
    w_sw_nxt    = r_sw;
    w_switch    = 1'b0;

    if (!enable) begin
      w_state_nxt = ST_FORCED;
      w_sel_nxt   = force_sel;
      w_beat_nxt  = '0;
    end else begin
      case (r_state)
        ST_FORCED: w_state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (w_cur_v)      w_state_nxt = ST_GRANT;
          else if (w_oth_v) w_switch    = 1'b1;
        end
        ST_SETTLE: begin
          w_beat_nxt  = w_beat_inc;
          w_state_nxt = ST_GRANT;
        end
        ST_GRANT: begin
          if (w_burst_end) begin
            if (w_oth_v) w_switch   = 1'b1;
            else         w_beat_nxt = '0;
          end else if (!w_cur_v && w_oth_v) begin
            w_switch = 1'b1;
          end else if (!w_cur_v) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt = w_beat_inc;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_switch) begin
      w_sel_nxt   = ~r_sel;
      w_beat_nxt  = '0;
      w_sw_nxt    = r_sw + C_SW_ONE;
      w_state_nxt = ST_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_beat  <= '0;
      r_sw    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_beat  <= w_beat_nxt;
      r_sw    <= w_sw_nxt;
    end
  end

  assign select_out   = r_sel;
  assign beat_cnt     = r_beat;
  assign switch_count = r_sw;
  assign state_out    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_axis_mux_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_mux_scheduler                                                    |
// | Randomized + directed bench with queue scoreboard and reference model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axis_mux_scheduler;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s0_tvalid = 1'b0, s0_tready = 1'b0;
  logic          s1_tvalid = 1'b0, s1_tready = 1'b0;
  logic          enable = 1'b1, force_sel = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          select_out;
  logic [CW-1:0] beat_cnt;
  logic [31:0]   switch_count;
  logic [1:0]    state_out;

  axis_mux_scheduler #(.CNT_W(CW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s0_tvalid    (s0_tvalid),
    .s0_tready    (s0_tready),
    .s1_tvalid    (s1_tvalid),
    .s1_tready    (s1_tready),
    .enable       (enable),
    .force_sel    (force_sel),
    .burst_len    (burst_len),
    .select_out   (select_out),
    .beat_cnt     (beat_cnt),
    .switch_count (switch_count),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          cnt;
    int unsigned sw;
    int          st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase 0=idle, 1=settle, 2=grant, 3=forced.
  int          m_sel = 0;
  int          m_cnt = 0;
  int unsigned m_sw  = 0;
  int          m_ph  = 0;

  task automatic model_step(input int v0, input int r0, input int v1, input int r1,
                            input int en, input int fs, input int rn, input int bl);
    int cv, ov, hs, sw_now;
    cv = (m_sel == 1) ? v1 : v0;
    ov = (m_sel == 1) ? v0 : v1;
    hs = cv & ((m_sel == 1) ? r1 : r0);
    sw_now = 0;
    if (rn == 0) begin
      m_sel = 0; m_cnt = 0; m_sw = 0; m_ph = 0;
    end else if (en == 0) begin
      m_ph = 3; m_sel = fs; m_cnt = 0;
    end else if (m_ph == 3) begin
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (cv == 1) m_ph = 2;
      else if (ov == 1) sw_now = 1;
    end else if (m_ph == 1) begin
      m_cnt = (m_cnt + hs > CMAX) ? CMAX : m_cnt + hs;
      m_ph  = 2;
    end else begin
      if (bl != 0 && hs == 1 && m_cnt + 1 >= bl) begin
        if (ov == 1) sw_now = 1;
        else m_cnt = 0;
      end else if (cv == 0) begin
        if (ov == 1) sw_now = 1;
        else m_ph = 0;
      end else begin
        m_cnt = (m_cnt + hs > CMAX) ? CMAX : m_cnt + hs;
      end
    end
    if (sw_now == 1) begin
      m_sel = 1 - m_sel; m_cnt = 0; m_sw = m_sw + 1; m_ph = 1;
    end
  endtask

  task automatic drive(input int v0, input int r0, input int v1, input int r1,
                       input int en, input int fs, input int rn, input int bl);
    exp_t e;
    logic [CW-1:0] blv;
    @(negedge clk);
    blv       = bl[CW-1:0];
    s0_tvalid = v0[0]; s0_tready = r0[0];
    s1_tvalid = v1[0]; s1_tready = r1[0];
    enable    = en[0]; force_sel = fs[0];
    resetn    = rn[0]; burst_len = blv;
    model_step(v0, r0, v1, r1, en, fs, rn, bl);
    e.sel = m_sel; e.cnt = m_cnt; e.sw = m_sw; e.st = m_ph;
    q.push_back(e);
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (int'(select_out) != e.sel) begin
          errors++;
          $display("FAIL select_out t=%0t actual=%0d required=%0d", $time, select_out, e.sel);
        end
        checks++;
        if (int'(beat_cnt) != e.cnt) begin
          errors++;
          $display("FAIL beat_cnt t=%0t actual=%0d required=%0d", $time, beat_cnt, e.cnt);
        end
        checks++;
        if (switch_count != e.sw) begin
          errors++;
          $display("FAIL switch_count t=%0t actual=%0d required=%0d", $time, switch_count, e.sw);
        end
        checks++;
        if (int'(state_out) != e.st) begin
          errors++;
          $display("FAIL state_out t=%0t actual=%0d required=%0d", $time, state_out, e.st);
        end
      end
    end
  end

  initial begin
    int bl, p0, p1;
    // Reset state
    repeat (3) drive(0, 0, 0, 0, 1, 0, 0, 0);
    // Burst of 4, both always valid and ready
    repeat (40) drive(1, 1, 1, 1, 1, 0, 1, 4);
    // Unlimited burst: s0 for 10 beats then drops, s1 valid throughout
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (11) drive(1, 1, 1, 1, 1, 0, 1, 0);
    repeat (6)  drive(0, 1, 1, 1, 1, 0, 1, 0);
    // Burst of 3 with s0 only
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (12) drive(1, 1, 0, 0, 1, 0, 1, 3);
    // Unlimited burst saturates the counter
    repeat (22) drive(1, 1, 0, 0, 1, 0, 1, 0);
    // Forced select mid-burst, then release
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (6) drive(1, 1, 1, 1, 1, 0, 1, 4);
    repeat (5) drive(1, 1, 1, 1, 0, 1, 1, 4);
    repeat (4) drive(1, 1, 1, 1, 1, 0, 1, 4);
    // Reset pulse while granting s1 with beats already counted
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    repeat (8) drive(1, 1, 1, 1, 1, 0, 1, 4);
    drive(1, 1, 1, 1, 1, 0, 0, 4);
    repeat (4) drive(1, 1, 1, 1, 1, 0, 1, 4);
    // Forced select right out of reset
    drive(1, 1, 1, 1, 0, 1, 0, 2);
    repeat (3) drive(1, 1, 1, 1, 0, 1, 1, 2);
    // burst_len=1 alternation; s1 ready during select lag
    repeat (16) drive(1, 1, 1, 1, 1, 0, 1, 1);
    repeat (16) drive(1, $urandom_range(0, 1), 1, 1, 1, 0, 1, 2);
    // Lowering burst_len below the running count ends the burst
    repeat (6) drive(1, 1, 0, 0, 1, 0, 1, 8);
    repeat (4) drive(1, 1, 1, 1, 1, 0, 1, 2);

    // Randomized segments
    for (int seg = 0; seg < 24; seg++) begin
      case ($urandom_range(0, 3))
        0:       bl = 0;
        1:       bl = 1;
        default: bl = $urandom_range(0, CMAX);
      endcase
      p0 = $urandom_range(10, 100);
      p1 = $urandom_range(10, 100);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 49) == 0) bl = $urandom_range(0, CMAX);
        drive(($urandom_range(1, 100) <= p0) ? 1 : 0, $urandom_range(0, 3) != 0 ? 1 : 0,
              ($urandom_range(1, 100) <= p1) ? 1 : 0, $urandom_range(0, 3) != 0 ? 1 : 0,
              ($urandom_range(0, 39) != 0) ? 1 : 0, $urandom_range(0, 1),
              ($urandom_range(0, 199) != 0) ? 1 : 0, bl);
      end
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
